// File: rtl/ringlock_pkg.sv
// Shared types and route indices for the ring interlock request controller.
package ringlock_pkg;

    localparam int N_ROUTES = 8;

    localparam int ROUTE_A = 0;
    localparam int ROUTE_B = 1;
    localparam int ROUTE_C = 2;
    localparam int ROUTE_D = 3;
    localparam int ROUTE_E = 4;
    localparam int ROUTE_F = 5;
    localparam int ROUTE_G = 6;
    localparam int ROUTE_H = 7;

    typedef enum logic [2:0] {
        FREE,
        PENDING,
        LOCKED,
        OCCUPIED,
        RELEASING
    } route_state_t;

    typedef enum logic {
        SCAN,
        PRESENT
    } arb_state_t;

    // A held route keeps its line asserted towards the interlock.
    function automatic logic is_held(input route_state_t st);
        return (st == LOCKED) || (st == OCCUPIED) || (st == RELEASING);
    endfunction

endpackage

// File: rtl/route_slot.sv
// One route slot: request/lock/release state, release timer and retry limit.
// ROUTE_TIMEOUT_EN adds the failed-grant counter and the o_fault drop pulse.
//
// state     | meaning
// FREE      | idle, accepts a new request
// PENDING   | waiting to be presented and granted by the interlock
// LOCKED    | route held, signal at proceed
// OCCUPIED  | train on the route, signal back at stop
// RELEASING | route still held while the release timer runs out
module route_slot
    import ringlock_pkg::*;
#(
    parameter int REL_DELAY    = 100,
    parameter int TMR_W        = 8,
    parameter int MAX_ATTEMPTS = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_cancel,
    input  logic i_track_occ,
    input  logic i_grant_ok,
    input  logic i_grant_fail,
    output logic o_pending,
    output logic o_held_nxt,
    output logic o_locked,
    output logic o_signal_clear,
    output logic o_fault
);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(REL_DELAY - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    route_state_t     r_state;
    route_state_t     w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             w_drop;
    logic             r_locked;
    logic             r_signal_clear;

`ifdef ROUTE_TIMEOUT_EN
    localparam int               ATT_W    = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [ATT_W-1:0] ATT_LAST = ATT_W'(MAX_ATTEMPTS - 1);
    localparam logic [ATT_W-1:0] ATT_ONE  = ATT_W'(1);

    logic [ATT_W-1:0] r_att;
    logic [ATT_W-1:0] w_att_nxt;
    logic             r_fault;

    // A cancel in the same cycle wins over the drop, so no fault is raised then.
    assign w_drop = (r_state == PENDING) && !i_cancel && i_grant_fail && (r_att == ATT_LAST);

    always_comb begin
        w_att_nxt = r_att;
        if ((r_state != PENDING) || i_cancel || i_grant_ok || w_drop)
            w_att_nxt = '0;
        else if (i_grant_fail)
            w_att_nxt = r_att + ATT_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_att   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_att   <= w_att_nxt;
            r_fault <= w_drop;
        end
    end

    assign o_fault = r_fault;
`else
    localparam int max_attempts_unused = MAX_ATTEMPTS;
    logic w_grant_fail_unused;

    assign w_grant_fail_unused = i_grant_fail;
    assign w_drop              = 1'b0;
    assign o_fault             = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            FREE: begin
                if (i_req && !i_cancel)
                    w_state_nxt = PENDING;
            end
            PENDING: begin
                if (i_cancel || w_drop)
                    w_state_nxt = FREE;
                else if (i_grant_ok)
                    w_state_nxt = LOCKED;
            end
            LOCKED: begin
                if (i_track_occ) begin
                    w_state_nxt = OCCUPIED;
                end else if (i_cancel) begin
                    w_state_nxt = RELEASING;
                    w_tmr_nxt   = TMR_LOAD;
                end
            end
            OCCUPIED: begin
                if (!i_track_occ) begin
                    w_state_nxt = RELEASING;
                    w_tmr_nxt   = TMR_LOAD;
                end
            end
            RELEASING: begin
                if (r_tmr == '0)
                    w_state_nxt = FREE;
                else
                    w_tmr_nxt = r_tmr - TMR_ONE;
            end
            default: w_state_nxt = FREE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= FREE;
            r_tmr          <= '0;
            r_locked       <= 1'b0;
            r_signal_clear <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tmr          <= w_tmr_nxt;
            r_locked       <= is_held(w_state_nxt);
            r_signal_clear <= (w_state_nxt == LOCKED);
        end
    end

    assign o_pending      = (r_state == PENDING);
    assign o_held_nxt     = is_held(w_state_nxt);
    assign o_locked       = r_locked;
    assign o_signal_clear = r_signal_clear;

endmodule

// File: rtl/route_lock_controller.sv
// Request side of the ring interlock: round-robin arbiter presenting one pending route at a time.
// Optional ROUTE_TIMEOUT_EN drops requests after MAX_ATTEMPTS failed grant checks.
//
// state   | meaning
// SCAN    | look for the first pending slot at or after the rr pointer
// PRESENT | candidate line is up; sample its grant this cycle
module route_lock_controller
    import ringlock_pkg::*;
#(
    parameter int REL_DELAY    = 100,
    parameter int TMR_W        = 8,
    parameter int MAX_ATTEMPTS = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_ROUTES-1:0] i_req,
    input  logic [N_ROUTES-1:0] i_cancel,
    input  logic [N_ROUTES-1:0] i_grant,
    input  logic [N_ROUTES-1:0] i_track_occ,
    output logic [N_ROUTES-1:0] o_route_lines,
    output logic [N_ROUTES-1:0] o_signal_clear,
    output logic [N_ROUTES-1:0] o_locked,
    output logic [N_ROUTES-1:0] o_fault
);

    localparam int PTR_W = $clog2(N_ROUTES);

    arb_state_t          r_arb;
    arb_state_t          w_arb_nxt;
    logic [PTR_W-1:0]    r_rr;
    logic [PTR_W-1:0]    w_rr_nxt;
    logic [PTR_W-1:0]    r_cand;
    logic [PTR_W-1:0]    w_cand_nxt;
    logic [PTR_W-1:0]    w_pick;
    logic                w_found;
    logic                w_cand_ok;
    logic [N_ROUTES-1:0] w_pending;
    logic [N_ROUTES-1:0] w_held_nxt;
    logic [N_ROUTES-1:0] w_grant_ok;
    logic [N_ROUTES-1:0] w_grant_fail;
    logic [N_ROUTES-1:0] w_cand_oh;
    logic [N_ROUTES-1:0] r_route_lines;

    for (genvar g = 0; g < N_ROUTES; g++) begin : g_slot
        route_slot #(
            .REL_DELAY    (REL_DELAY),
            .TMR_W        (TMR_W),
            .MAX_ATTEMPTS (MAX_ATTEMPTS)
        ) u_slot (
            .i_clk          (i_clk),
            .i_rst          (i_rst),
            .i_req          (i_req[g]),
            .i_cancel       (i_cancel[g]),
            .i_track_occ    (i_track_occ[g]),
            .i_grant_ok     (w_grant_ok[g]),
            .i_grant_fail   (w_grant_fail[g]),
            .o_pending      (w_pending[g]),
            .o_held_nxt     (w_held_nxt[g]),
            .o_locked       (o_locked[g]),
            .o_signal_clear (o_signal_clear[g]),
            .o_fault        (o_fault[g])
        );
    end

    // Walk backwards so the last hit is the first pending slot at or after r_rr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        for (int i = N_ROUTES - 1; i >= 0; i--) begin
            if (w_pending[(int'(r_rr) + i) % N_ROUTES]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'((int'(r_rr) + i) % N_ROUTES);
            end
        end
    end

    assign w_cand_ok = i_grant[r_cand] & ~i_track_occ[r_cand];

    always_comb begin
        w_arb_nxt    = r_arb;
        w_rr_nxt     = r_rr;
        w_cand_nxt   = r_cand;
        w_grant_ok   = '0;
        w_grant_fail = '0;
        case (r_arb)
            SCAN: begin
                if (w_found) begin
                    w_cand_nxt = w_pick;
                    w_arb_nxt  = PRESENT;
                end
            end
            PRESENT: begin
                if (w_cand_ok)
                    w_grant_ok[r_cand] = 1'b1;
                else
                    w_grant_fail[r_cand] = 1'b1;
                w_rr_nxt  = PTR_W'((int'(r_cand) + 1) % N_ROUTES);
                w_arb_nxt = SCAN;
            end
            default: w_arb_nxt = SCAN;
        endcase
    end

    always_comb begin
        w_cand_oh = '0;
        if (w_arb_nxt == PRESENT)
            w_cand_oh[w_cand_nxt] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arb         <= SCAN;
            r_rr          <= '0;
            r_cand        <= '0;
            r_route_lines <= '0;
        end else begin
            r_arb         <= w_arb_nxt;
            r_rr          <= w_rr_nxt;
            r_cand        <= w_cand_nxt;
            r_route_lines <= w_held_nxt | w_cand_oh;
        end
    end

    assign o_route_lines = r_route_lines;

endmodule

// File: tb/tb_route_lock_controller.sv
// Bench for route_lock_controller: vector table, corner sequences and a random run against a route model.
module tb_route_lock_controller;
    import ringlock_pkg::*;

    localparam int REL  = 100;
    localparam int MAXA = 15;
    // Interlock conflict pairs: A<->C, B<->E.
    localparam logic [7:0] CONF [8] = '{8'h04, 8'h10, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    localparam int S_FREE = 0, S_PEND = 1, S_LOCK = 2, S_OCC = 3, S_REL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, cancel, occ, grant;
    logic [7:0] o_route_lines, o_signal_clear, o_locked, o_fault;
    logic       conf_en;
    logic [7:0] deny;
    int         n_checks = 0;
    int         n_errors = 0;

    typedef struct {
        logic [7:0] req, cancel, occ, lines, sig, lk;
    } vec_t;
    vec_t vecs [10];

    int         m_st [8];
    int         m_rel [8];
    int         m_fails [8];
    int         m_cand;
    int         m_rr;
    logic [7:0] m_fault;

    always #5 clk = ~clk;

    function automatic logic [7:0] interlock(input logic [7:0] lines, input logic cen, input logic [7:0] dn);
        logic [7:0] g;
        g = '0;
        for (int r = 0; r < 8; r++)
            g[r] = lines[r] & ~dn[r] & ~(cen & (|(lines & CONF[r])));
        return g;
    endfunction

    always_comb grant = interlock(o_route_lines, conf_en, deny);

    route_lock_controller dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_cancel       (cancel),
        .i_grant        (grant),
        .i_track_occ    (occ),
        .o_route_lines  (o_route_lines),
        .o_signal_clear (o_signal_clear),
        .o_locked       (o_locked),
        .o_fault        (o_fault)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; cancel = '0; occ = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_st[r] = S_FREE; m_rel[r] = 0; m_fails[r] = 0;
        end
        m_cand = -1; m_rr = 0; m_fault = '0;
    endtask

    function automatic logic [7:0] m_held();
        logic [7:0] h;
        h = '0;
        for (int r = 0; r < 8; r++)
            h[r] = (m_st[r] == S_LOCK) || (m_st[r] == S_OCC) || (m_st[r] == S_REL);
        return h;
    endfunction

    function automatic logic [7:0] m_lines();
        logic [7:0] l;
        l = m_held();
        if (m_cand >= 0) l[m_cand] = 1'b1;
        return l;
    endfunction

    function automatic logic [7:0] m_sig();
        logic [7:0] s;
        for (int r = 0; r < 8; r++) s[r] = (m_st[r] == S_LOCK);
        return s;
    endfunction

    task automatic model_edge(input logic [7:0] rq, input logic [7:0] cn, input logic [7:0] oc);
        logic [7:0] g, ok_v, fail_v;
        int nxt;
        g = interlock(m_lines(), conf_en, deny);
        ok_v = '0; fail_v = '0; nxt = -1;
        if (m_cand >= 0) begin
            if (g[m_cand] && !oc[m_cand]) ok_v[m_cand] = 1'b1;
            else fail_v[m_cand] = 1'b1;
            m_rr = (m_cand + 1) % 8;
        end else begin
            for (int k = 0; k < 8; k++)
                if (nxt < 0 && m_st[(m_rr + k) % 8] == S_PEND) nxt = (m_rr + k) % 8;
        end
        m_fault = '0;
        for (int r = 0; r < 8; r++) begin
            case (m_st[r])
                S_FREE: if (rq[r] && !cn[r]) begin m_st[r] = S_PEND; m_fails[r] = 0; end
                S_PEND: begin
                    if (cn[r]) begin m_st[r] = S_FREE; m_fails[r] = 0; end
                    else if (ok_v[r]) begin m_st[r] = S_LOCK; m_fails[r] = 0; end
                    else if (fail_v[r]) begin
                        m_fails[r]++;
`ifdef ROUTE_TIMEOUT_EN
                        if (m_fails[r] == MAXA) begin
                            m_st[r] = S_FREE; m_fault[r] = 1'b1; m_fails[r] = 0;
                        end
`endif
                    end
                end
                S_LOCK: begin
                    if (oc[r]) m_st[r] = S_OCC;
                    else if (cn[r]) begin m_st[r] = S_REL; m_rel[r] = REL; end
                end
                S_OCC: if (!oc[r]) begin m_st[r] = S_REL; m_rel[r] = REL; end
                default: begin
                    m_rel[r]--;
                    if (m_rel[r] == 0) m_st[r] = S_FREE;
                end
            endcase
        end
        m_cand = nxt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, seen, n;
        int lock_at [8];

        vecs[0] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01};
        vecs[3] = '{8'h02, 8'h02, 8'h00, 8'h01, 8'h01, 8'h01};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01};
        vecs[5] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01};
        vecs[6] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
        vecs[8] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
        vecs[9] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};

        conf_en = 1'b1; deny = '0;
        do_reset();
        check("reset lines", o_route_lines, 8'h00);
        check("reset sig", o_signal_clear, 8'h00);
        check("reset locked", o_locked, 8'h00);
        check("reset fault", o_fault, 8'h00);

        // Single request, B req+cancel, train on A with ignored cancel.
        for (int i = 0; i < 10; i++) begin
            req = vecs[i].req; cancel = vecs[i].cancel; occ = vecs[i].occ;
            step();
            check($sformatf("vec%0d lines", i), o_route_lines, vecs[i].lines);
            check($sformatf("vec%0d sig", i), o_signal_clear, vecs[i].sig);
            check($sformatf("vec%0d locked", i), o_locked, vecs[i].lk);
        end

        // Conflict: C denied while A held, locks after A releases.
        do_reset();
        req = 8'h01; step(); req = '0; step(); step();
        check("conf A locked", o_locked, 8'h01);
        req = 8'h04; step(); req = '0;
        cnt = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_route_lines[ROUTE_C]) cnt++;
            if (o_locked[ROUTE_C]) seen = 1;
        end
        check_int("conf C presentations", cnt, 5);
        check_int("conf C held off", seen, 0);
        cancel = 8'h01; step(); cancel = '0;
        n = 1;
        while (n < 300 && !o_locked[ROUTE_C]) begin step(); n++; end
        n_checks++;
        if (!o_locked[ROUTE_C] || n > REL + 4) begin
            n_errors++;
            $display("FAIL conf C lock delay: got %0d cycles required <= %0d", n, REL + 4);
        end
        check("conf after lock", o_locked, 8'h04);

        // Train passage timing.
        do_reset();
        req = 8'h01; step(); req = '0; step(); step();
        occ = 8'h01; step();
        check("train sig drop", o_signal_clear, 8'h00);
        check("train locked occ", o_locked, 8'h01);
        for (int i = 0; i < 19; i++) step();
        occ = '0;
        for (int k = 1; k <= 101; k++) begin
            step();
            if (k == 50) check("train releasing sig", o_signal_clear, 8'h00);
            if (k == 100) check("train locked at 100", o_locked, 8'h01);
            if (k == 101) check("train freed at 101", o_locked, 8'h00);
        end

        // All eight requested at once, no conflicts.
        do_reset(); conf_en = 1'b0;
        req = 8'hFF; step(); req = '0;
        for (int r = 0; r < 8; r++) lock_at[r] = -1;
        for (int c = 2; c <= 20; c++) begin
            step();
            for (int r = 0; r < 8; r++)
                if (o_locked[r] && lock_at[r] < 0) lock_at[r] = c;
        end
        for (int r = 0; r < 8; r++) check_int($sformatf("sweep lock cycle r%0d", r), lock_at[r], 3 + 2 * r);
        conf_en = 1'b1;

        // Reset in PRESENT, then in RELEASING.
        do_reset();
        req = 8'h01; step(); req = '0; step();
        check("rstP present line", o_route_lines, 8'h01);
        rst = 1'b1; step(); rst = 1'b0;
        check("rstP lines", o_route_lines, 8'h00);
        check("rstP locked", o_locked, 8'h00);
        req = 8'h01; step(); req = '0; step();
        check("rstP relock line", o_route_lines, 8'h01);
        step();
        check("rstP relock locked", o_locked, 8'h01);
        check("rstP relock sig", o_signal_clear, 8'h01);
        cancel = 8'h01; step(); cancel = '0;
        for (int i = 0; i < 5; i++) step();
        check("rstR releasing", o_locked, 8'h01);
        rst = 1'b1; step(); rst = 1'b0;
        check("rstR lines", o_route_lines, 8'h00);
        check("rstR locked", o_locked, 8'h00);
        check("rstR sig", o_signal_clear, 8'h00);
        req = 8'h02; step(); req = '0; step();
        check("rstR relock line", o_route_lines, 8'h02);
        step();
        check("rstR relock locked", o_locked, 8'h02);

        // Permanent denial of D.
        do_reset(); deny = 8'h08;
        req = 8'h08; step(); req = '0;
        cnt = 0; seen = 0; n = 0;
`ifdef ROUTE_TIMEOUT_EN
        for (int i = 0; i < 120; i++) begin
            step();
            if (o_route_lines[ROUTE_D]) cnt++;
            if (o_fault[ROUTE_D]) seen++;
            if (o_locked[ROUTE_D]) n = 1;
        end
        check_int("timeout checks", cnt, MAXA);
        check_int("timeout fault cycles", seen, 1);
`else
        for (int i = 0; i < 1000; i++) begin
            step();
            if (o_route_lines[ROUTE_D]) cnt++;
            if (o_fault != '0) seen++;
            if (o_locked[ROUTE_D]) n = 1;
        end
        check_int("retry presentations", cnt, 500);
        check_int("retry fault cycles", seen, 0);
`endif
        check_int("deny never locked", n, 0);
        deny = '0;

        // Random run against the model.
        do_reset(); model_reset(); conf_en = 1'b1;
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            req = '0; cancel = '0;
            for (int r = 0; r < 8; r++) begin
                if ($urandom_range(0, 15) == 0) req[r] = 1'b1;
                if ($urandom_range(0, 47) == 0) cancel[r] = 1'b1;
                if ($urandom_range(0, 29) == 0) occ[r] = ~occ[r];
            end
            model_edge(req, cancel, occ);
            step();
            check($sformatf("rand c%0d lines", c), o_route_lines, m_lines());
            check($sformatf("rand c%0d sig", c), o_signal_clear, m_sig());
            check($sformatf("rand c%0d locked", c), o_locked, m_held());
            check($sformatf("rand c%0d fault", c), o_fault, m_fault);
            if (m_held() != '0) cnt++;
        end
        check_int("rand activity", (cnt > 100) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
